// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_pkg
// Purpose  : Framebuffer geometry, address width and writer FSM state
//            encoding, shared by the framebuffer writer and the VGA reader.
// Revision : 1.0 - initial release
// ============================================================================
package fb_pkg;

   localparam int unsigned WIDTH   = 640;            // pixels per line
   localparam int unsigned HEIGHT  = 400;            // lines per frame
   localparam int unsigned ADDR_W  = 18;             // framebuffer address width
   localparam int unsigned FB_SIZE = WIDTH * HEIGHT; // pixels per bank
   localparam int unsigned X_W     = 10;             // pixel x coordinate width
   localparam int unsigned Y_W     = 9;              // pixel y coordinate width

   typedef enum logic [1:0] {
      ST_CLEAR     = 2'd0,
      ST_DRAW      = 2'd1,
      ST_WAIT_SWAP = 2'd2
   } fb_state_t;

endpackage
`default_nettype wire

// File: rtl/fb_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : fb_writer_if
// Purpose  : Pixel handshake, frame control and back-buffer write port of the
//            framebuffer writer. The slave modport is the writer itself; the
//            master modport is the pixel producer / memory / VGA side.
// Revision : 1.0 - initial release
// ============================================================================
interface fb_writer_if #(
   parameter int unsigned ADDR_W = fb_pkg::ADDR_W
) ();

   // pixel handshake
   logic                    pix_valid;
   logic                    pix_ready;
   logic [fb_pkg::X_W-1:0]  pix_x;
   logic [fb_pkg::Y_W-1:0]  pix_y;
   logic                    pix_value;

   // frame control
   logic                    swap;
   logic                    frame_done;
   logic                    front_bank;
   logic                    draw_ready;

   // back-buffer write port
   logic                    write_en;
   logic [ADDR_W-1:0]       write_addr;
   logic                    write_data;

   modport slave (
      input  pix_valid, pix_x, pix_y, pix_value, swap, frame_done,
      output pix_ready, front_bank, draw_ready, write_en, write_addr, write_data
   );

   modport master (
      output pix_valid, pix_x, pix_y, pix_value, swap, frame_done,
      input  pix_ready, front_bank, draw_ready, write_en, write_addr, write_data
   );

endinterface
`default_nettype wire

// File: rtl/fb_addr.sv
`default_nettype none
// ============================================================================
// Module   : fb_addr
// Purpose  : Registered pixel address generator. Turns an accepted (x, y)
//            into the linear address y*WIDTH+x one cycle later, together with
//            a write strobe that is only set for in-range coordinates.
// Revision : 1.0 - initial release
// ============================================================================
module fb_addr #(
   parameter int unsigned WIDTH  = fb_pkg::WIDTH,
   parameter int unsigned HEIGHT = fb_pkg::HEIGHT,
   parameter int unsigned ADDR_W = fb_pkg::ADDR_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   valid,
   input  logic [fb_pkg::X_W-1:0] x,
   input  logic [fb_pkg::Y_W-1:0] y,
   input  logic                   value,
   output logic                   we,
   output logic [ADDR_W-1:0]      addr,
   output logic                   data
);

   import fb_pkg::*;

   logic              in_range;
   logic [ADDR_W-1:0] lin_addr;

   // Coordinates are compared at full width so x/y values at or past the
   // geometry edge are caught rather than aliased.
   assign in_range = (32'(x) < WIDTH) && (32'(y) < HEIGHT);

   // Every operand is widened to ADDR_W before the multiply so the product of
   // in-range coordinates is never truncated.
   assign lin_addr = ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);

   // One-cycle address pipeline; reset drops any write still in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we   <= 1'b0;
         addr <= '0;
         data <= 1'b0;
      end else begin
         we   <= valid & in_range;
         addr <= lin_addr;
         data <= value;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : fb_writer
// Purpose  : Double-buffered framebuffer writer. Clears the back bank, then
//            accepts pixels from a producer until the frame is done, then
//            waits for the VGA frame-boundary swap to flip banks.
// Revision : 1.0 - initial release
// ============================================================================
module fb_writer #(
   parameter int unsigned WIDTH  = fb_pkg::WIDTH,
   parameter int unsigned HEIGHT = fb_pkg::HEIGHT,
   parameter int unsigned ADDR_W = fb_pkg::ADDR_W
) (
   input  logic       clk,
   input  logic       rst_n,
   fb_writer_if.slave bus
);

   import fb_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

   fb_state_t         state;
   logic [ADDR_W-1:0] clr_cnt;
   logic [ADDR_W-1:0] clr_addr;
   logic              clr_we;
   logic              pix_ready_q;
   logic              draw_ready_q;
   logic              front_bank_q;

   logic              handshake;
   logic              pix_we;
   logic [ADDR_W-1:0] pix_addr;
   logic              pix_data;

   assign handshake = bus.pix_valid & pix_ready_q;

   fb_addr #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .ADDR_W (ADDR_W)
   ) u_fb_addr (
      .clk   (clk),
      .rst_n (rst_n),
      .valid (handshake),
      .x     (bus.pix_x),
      .y     (bus.pix_y),
      .value (bus.pix_value),
      .we    (pix_we),
      .addr  (pix_addr),
      .data  (pix_data)
   );

   // Frame FSM with registered outputs: clear sweep, draw window, bank swap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_CLEAR;
         clr_cnt      <= '0;
         clr_addr     <= '0;
         clr_we       <= 1'b0;
         pix_ready_q  <= 1'b0;
         draw_ready_q <= 1'b0;
         front_bank_q <= 1'b0;
      end else begin
         clr_we <= 1'b0;
         case (state)
            ST_CLEAR: begin
               clr_we   <= 1'b1;
               clr_addr <= clr_cnt;
               // The counter parks on the last address; the next sweep
               // only starts from a fresh swap or reset.
               if (clr_cnt == LAST_ADDR) begin
                  state        <= ST_DRAW;
                  pix_ready_q  <= 1'b1;
                  draw_ready_q <= 1'b1;
               end else begin
                  clr_cnt <= clr_cnt + ADDR_W'(1);
               end
            end
            ST_DRAW: begin
               // A swap arriving with frame_done is left for WAIT_SWAP to
               // see on a later pulse.
               if (bus.frame_done) begin
                  state        <= ST_WAIT_SWAP;
                  pix_ready_q  <= 1'b0;
                  draw_ready_q <= 1'b0;
               end
            end
            ST_WAIT_SWAP: begin
               if (bus.swap) begin
                  front_bank_q <= ~front_bank_q;
                  clr_cnt      <= '0;
                  state        <= ST_CLEAR;
               end
            end
            default: begin
               state        <= ST_CLEAR;
               clr_cnt      <= '0;
               pix_ready_q  <= 1'b0;
               draw_ready_q <= 1'b0;
            end
         endcase
      end
   end

   // Merge the clear sweep and the pixel pipeline onto the single write port;
   // the two never overlap, the clear path simply wins the mux.
   always_comb begin
      bus.write_en   = clr_we | pix_we;
      bus.write_addr = clr_we ? clr_addr : pix_addr;
      bus.write_data = clr_we ? 1'b0 : pix_data;
   end

   assign bus.pix_ready  = pix_ready_q;
   assign bus.draw_ready = draw_ready_q;
   assign bus.front_bank = front_bank_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_writer
// Purpose  : Directed self-checking bench for fb_writer. Uses a short frame
//            (640 x 16) so that full clear sweeps stay quick while keeping the
//            line width and the x/y boundary behaviour of the real geometry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_writer;

   localparam int unsigned T_WIDTH  = 640;
   localparam int unsigned T_HEIGHT = 16;
   localparam int unsigned ADDR_W   = 18;
   localparam int          FB_LAST  = T_WIDTH * T_HEIGHT - 1;   // 10239

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;

   fb_writer_if #(.ADDR_W(ADDR_W)) bus ();

   fb_writer #(
      .WIDTH  (T_WIDTH),
      .HEIGHT (T_HEIGHT),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Walks a run of clear writes, one address per cycle, optionally firing a
   // one-cycle swap + frame_done pulse at address pulse_idx.
   task automatic run_sweep(input string tag, input int first, input int last, input int pulse_idx);
      int bad;
      int bad_rdy;
      bad     = 0;
      bad_rdy = 0;
      for (int i = first; i <= last; i++) begin
         if (!(bus.write_en === 1'b1 && bus.write_addr === ADDR_W'(i) && bus.write_data === 1'b0))
            bad++;
         if (i < FB_LAST && bus.pix_ready !== 1'b0)
            bad_rdy++;
         bus.swap       = (i == pulse_idx);
         bus.frame_done = (i == pulse_idx);
         tick();
      end
      bus.swap       = 1'b0;
      bus.frame_done = 1'b0;
      check({tag, "_writes_bad"}, bad, 0);
      check({tag, "_ready_bad"}, bad_rdy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int bad;
      n_assert       = 0;
      n_fail         = 0;
      rst_n          = 1'b0;
      bus.pix_valid  = 1'b0;
      bus.pix_x      = '0;
      bus.pix_y      = '0;
      bus.pix_value  = 1'b0;
      bus.swap       = 1'b0;
      bus.frame_done = 1'b0;

      // Reset state
      repeat (3) tick();
      check("rst_write_en",   32'(bus.write_en),   0);
      check("rst_pix_ready",  32'(bus.pix_ready),  0);
      check("rst_draw_ready", 32'(bus.draw_ready), 0);
      check("rst_front_bank", 32'(bus.front_bank), 0);

      // First clear write lands in the first cycle with rst_n sampled high;
      // swap/frame_done pulsed mid-sweep must be ignored.
      rst_n = 1'b1;
      tick();
      check("first_clear_addr", 32'(bus.write_addr), 0);
      run_sweep("sweep1", 0, FB_LAST, 100);
      check("sweep1_end_we",         32'(bus.write_en),   0);
      check("sweep1_end_draw_ready", 32'(bus.draw_ready), 1);
      check("sweep1_end_pix_ready",  32'(bus.pix_ready),  1);
      check("sweep1_end_front_bank", 32'(bus.front_bank), 0);

      // Basic pixel (5,2,1) -> addr 1285
      bus.pix_valid = 1'b1; bus.pix_x = 10'd5; bus.pix_y = 9'd2; bus.pix_value = 1'b1;
      tick();
      check("px52_we",   32'(bus.write_en),   1);
      check("px52_addr", 32'(bus.write_addr), 1285);
      check("px52_data", 32'(bus.write_data), 1);
      bus.pix_valid = 1'b0;
      tick();
      check("px52_idle_we", 32'(bus.write_en), 0);

      // Out-of-range pixels accepted but dropped
      bus.pix_valid = 1'b1; bus.pix_x = 10'd640; bus.pix_y = 9'd0;
      tick();
      check("oor_x_we",    32'(bus.write_en),  0);
      check("oor_x_ready", 32'(bus.pix_ready), 1);
      bus.pix_x = 10'd0; bus.pix_y = 9'(T_HEIGHT);
      tick();
      check("oor_yh_we", 32'(bus.write_en), 0);
      bus.pix_y = 9'd400;
      tick();
      check("oor_y400_we",    32'(bus.write_en),  0);
      check("oor_y400_ready", 32'(bus.pix_ready), 1);

      // Back-to-back pixels (100,10,1) then (101,10,0)
      bus.pix_x = 10'd100; bus.pix_y = 9'd10; bus.pix_value = 1'b1;
      tick();
      check("b2b0_we",   32'(bus.write_en),   1);
      check("b2b0_addr", 32'(bus.write_addr), 6500);
      check("b2b0_data", 32'(bus.write_data), 1);
      bus.pix_x = 10'd101; bus.pix_value = 1'b0;
      tick();
      check("b2b1_we",   32'(bus.write_en),   1);
      check("b2b1_addr", 32'(bus.write_addr), 6501);
      check("b2b1_data", 32'(bus.write_data), 0);
      bus.pix_valid = 1'b0;

      // Swap during DRAW is ignored
      bus.swap = 1'b1;
      tick();
      bus.swap = 1'b0;
      check("draw_swap_front_bank", 32'(bus.front_bank), 0);
      check("draw_swap_draw_ready", 32'(bus.draw_ready), 1);

      // frame_done + swap + corner pixel (639,15,1) in the same cycle
      bus.pix_valid = 1'b1; bus.pix_x = 10'd639; bus.pix_y = 9'd15; bus.pix_value = 1'b1;
      bus.frame_done = 1'b1; bus.swap = 1'b1;
      tick();
      check("corner_we",         32'(bus.write_en),   1);
      check("corner_addr",       32'(bus.write_addr), FB_LAST);
      check("corner_data",       32'(bus.write_data), 1);
      check("fdone_pix_ready",   32'(bus.pix_ready),  0);
      check("fdone_draw_ready",  32'(bus.draw_ready), 0);
      check("fdone_front_bank",  32'(bus.front_bank), 0);

      // WAIT_SWAP: offered pixels and frame_done are ignored for 10 cycles
      bus.swap = 1'b0;
      bus.pix_x = 10'd3; bus.pix_y = 9'd3;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.write_en !== 1'b0 || bus.front_bank !== 1'b0 ||
             bus.pix_ready !== 1'b0 || bus.draw_ready !== 1'b0)
            bad++;
      end
      check("wait_swap_idle_bad", bad, 0);
      bus.pix_valid  = 1'b0;
      bus.frame_done = 1'b0;

      // Swap flips the bank and starts a fresh sweep
      bus.swap = 1'b1;
      tick();
      bus.swap = 1'b0;
      check("swap_front_bank", 32'(bus.front_bank), 1);
      check("swap_we",         32'(bus.write_en),   0);
      tick();
      run_sweep("sweep2", 0, 999, -1);

      // Reset at clear address 1000
      check("sweep2_at1000_we",   32'(bus.write_en),   1);
      check("sweep2_at1000_addr", 32'(bus.write_addr), 1000);
      rst_n = 1'b0;
      tick();
      check("midclr_rst_we",         32'(bus.write_en),   0);
      check("midclr_rst_front_bank", 32'(bus.front_bank), 0);
      check("midclr_rst_draw_ready", 32'(bus.draw_ready), 0);
      rst_n = 1'b1;
      tick();
      check("restart_front_bank", 32'(bus.front_bank), 0);
      run_sweep("sweep3", 0, FB_LAST, -1);
      check("sweep3_end_draw_ready", 32'(bus.draw_ready), 1);

      // Reset with a handshake in the same edge: pending write is dropped
      bus.pix_valid = 1'b1; bus.pix_x = 10'd5; bus.pix_y = 9'd2; bus.pix_value = 1'b1;
      rst_n = 1'b0;
      tick();
      check("middraw_rst_we",        32'(bus.write_en),  0);
      check("middraw_rst_pix_ready", 32'(bus.pix_ready), 0);
      bus.pix_valid = 1'b0;
      rst_n = 1'b1;
      tick();
      check("post_rst_clear_we",   32'(bus.write_en),   1);
      check("post_rst_clear_addr", 32'(bus.write_addr), 0);
      check("post_rst_clear_data", 32'(bus.write_data), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 SHALL have parameters: WIDTH, 640, pixels per line; HEIGHT, 400, lines per frame; ADDR_W, 18, framebuffer address width.
REQ-002 SHALL have ports, one per line: clk  in  1  sole clock, all logic on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 swap  in  1  one-cycle pulse from vga at frame boundary.
REQ-005 pix_valid  in  1; pix_ready  out  1  pixel handshake.
REQ-006 pix_x  in  10; pix_y  in  9; pix_value  in  1  pixel coordinate and colour bit.
REQ-007 frame_done  in  1  one-cycle pulse, producer finished drawing current frame.
REQ-008 write_en  out  1; write_addr  out  ADDR_W; write_data  out  1  back-buffer write port.
REQ-009 front_bank  out  1  bank index vga reads; back bank = ~front_bank.
REQ-010 draw_ready  out  1  high while in DRAW.

Function
REQ-011 SHALL implement FSM states CLEAR, DRAW, WAIT_SWAP.
REQ-012 CLEAR SHALL write 0 to every back-bank address 0..WIDTH*HEIGHT-1, one address per cycle, ascending, then enter DRAW; pix_ready=0 throughout.
REQ-013 DRAW SHALL hold pix_ready=1; a handshake is pix_valid&pix_ready.
REQ-014 Handshake with pix_x<WIDTH and pix_y<HEIGHT SHALL produce write_en=1, write_addr=pix_y*WIDTH+pix_x, write_data=pix_value exactly one cycle later (1-cycle registered latency).
REQ-015 Out-of-range handshake SHALL be accepted and dropped: no write_en.
REQ-016 Address arithmetic SHALL be unsigned, computed at ADDR_W bits, no truncation for in-range coordinates.
REQ-017 frame_done in DRAW SHALL move FSM to WAIT_SWAP next cycle; a same-cycle pixel handshake SHALL still be written.
REQ-018 WAIT_SWAP SHALL hold pix_ready=0; on swap, front_bank toggles next cycle and FSM enters CLEAR.
REQ-019 swap in CLEAR or DRAW SHALL be ignored (front_bank unchanged); frame_done outside DRAW SHALL be ignored.
REQ-020 swap and frame_done in same cycle while in DRAW SHALL enter WAIT_SWAP only; that swap is not consumed.
REQ-021 write_en SHALL be 1 only during CLEAR sweep and registered DRAW writes; write_addr/write_data don't-care when write_en=0.
REQ-022 Clear counter SHALL stop at WIDTH*HEIGHT-1; no wrap into a second sweep.

Reset
REQ-023 rst_n=0 at a clk edge SHALL set: state CLEAR, clear counter 0, front_bank 0, write_en 0, pix_ready 0, draw_ready 0.
REQ-024 Reset mid-CLEAR, mid-DRAW or in WAIT_SWAP SHALL abort the operation; pending pipelined write SHALL be discarded.
REQ-025 After reset release, first CLEAR write SHALL appear in the first cycle with rst_n=1 sampled high.

Structure
REQ-026 Shared package fb_pkg SHALL hold WIDTH, HEIGHT, ADDR_W, FB_SIZE=WIDTH*HEIGHT and the FSM state encoding, also used by vga.
REQ-027 One sub-module fb_addr SHALL compute registered y*WIDTH+x plus in-range flag; all else in fb_writer.

Verification
REQ-028 Reset release -> 256000 consecutive write_en cycles, addr 0..255999, data 0, then draw_ready=1, front_bank=0.
REQ-029 DRAW, pixel (x=5,y=2,v=1) -> next cycle write_en=1, write_addr=1285, write_data=1.
REQ-030 DRAW, pixel (x=640,y=0) and (x=0,y=400) -> pix_ready=1, no write_en.
REQ-031 frame_done with simultaneous pixel (639,399,1) -> write addr 255999; WAIT_SWAP; swap 10 cycles later -> front_bank=1, new CLEAR sweep.
REQ-032 swap pulses during CLEAR and DRAW -> front_bank stays 0.
REQ-033 rst_n low at clear addr 1000 -> write_en 0 next cycle; after release sweep restarts at addr 0, front_bank 0.
